// File: rtl/mandelbrot_pkg.sv
// Shared types, Q4.28 constants and helpers for the Mandelbrot frame controller.
// Optional feature macro: MANDEL_AUTO_ITER_EN (iteration limit follows zoom level).
`ifndef RGB_SIZE
`define RGB_SIZE 24
`endif

package mandelbrot_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_START,
        ST_RUN,
        ST_DONE
    } state_t;

    // Bit positions in the command vector; lower index wins.
    typedef enum logic [2:0] {
        CMD_HOME     = 3'd0,
        CMD_ZOOM_IN  = 3'd1,
        CMD_ZOOM_OUT = 3'd2,
        CMD_LEFT     = 3'd3,
        CMD_RIGHT    = 3'd4,
        CMD_UP       = 3'd5,
        CMD_DOWN     = 3'd6
    } cmd_idx_t;

    localparam int NUM_CMDS = 7;

    // Q4.28 fixed-point constants
    localparam logic [31:0] Q_ONE         = 32'h1000_0000;
    localparam logic [31:0] Q_TWO         = 32'h2000_0000;
    localparam logic [31:0] INIT_CENTER_R = 32'hF800_0000;
    localparam logic [31:0] INIT_CENTER_I = 32'h0000_0000;
    localparam logic [31:0] INIT_DELTA    = 32'd1258291;
    localparam logic [31:0] DELTA_MAX     = 32'd16777216;
    localparam int          PAN_SHIFT     = 5;
    localparam int          MAX_ITER      = 256;

    // Isolate the highest-priority (lowest-index) pending command as one-hot.
    function automatic logic [NUM_CMDS-1:0] pick_cmd(input logic [NUM_CMDS-1:0] pend);
        return pend & (~pend + 1'b1);
    endfunction

    // Signed add clamped to [-lim, +lim]; operands are pre-widened so the sum never wraps.
    function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                   input logic signed [63:0] b,
                                                   input logic signed [63:0] lim);
        logic signed [63:0] s;
        s = a + b;
        if (s > lim)
            return lim;
        else if (s < -lim)
            return -lim;
        return s;
    endfunction

endpackage

// File: rtl/mandelbrot_view_reg.sv
// View state (center, pixel delta, iteration limit) and its update for one decoded command.
// Optional feature macro: MANDEL_AUTO_ITER_EN adds a zoom-tracking iteration limit register.
module mandelbrot_view_reg
    import mandelbrot_pkg::*;
#(
    parameter int DATAW = 32,
    parameter int IMAGW = 28,
    parameter int ITERW = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                apply,
    input  logic [NUM_CMDS-1:0] cmd,
    output logic [DATAW-1:0]    delta,
    output logic [DATAW-1:0]    center_r_next,
    output logic [DATAW-1:0]    center_i_next,
    output logic [DATAW-1:0]    delta_next,
    output logic [ITERW-1:0]    max_iter
);

    // Pan limit is +/-2.0 in the fixed-point format
    localparam logic [DATAW-1:0] SAT_LIM = DATAW'(2) << IMAGW;

    logic [DATAW-1:0]   center_r;
    logic [DATAW-1:0]   center_i;
    logic [DATAW-1:0]   pan_step;
    logic signed [63:0] cr_wide;
    logic signed [63:0] ci_wide;
    logic signed [63:0] step_wide;
    logic signed [63:0] lim_wide;

    assign pan_step  = delta << PAN_SHIFT;
    assign cr_wide   = 64'($signed(center_r));
    assign ci_wide   = 64'($signed(center_i));
    assign step_wide = 64'(pan_step);
    assign lim_wide  = 64'(SAT_LIM);

    // Next view for the selected command; cmd is one-hot so the chain order is irrelevant
    always_comb begin
        center_r_next = center_r;
        center_i_next = center_i;
        delta_next    = delta;
        if (apply) begin
            if (cmd[CMD_HOME]) begin
                center_r_next = DATAW'(INIT_CENTER_R);
                center_i_next = DATAW'(INIT_CENTER_I);
                delta_next    = DATAW'(INIT_DELTA);
            end else if (cmd[CMD_ZOOM_IN]) begin
                delta_next = (delta > DATAW'(1)) ? (delta >> 1) : DATAW'(1);
            end else if (cmd[CMD_ZOOM_OUT]) begin
                delta_next = (delta >= (DATAW'(DELTA_MAX) >> 1)) ? DATAW'(DELTA_MAX) : (delta << 1);
            end else if (cmd[CMD_LEFT]) begin
                center_r_next = DATAW'(sat_add(cr_wide, -step_wide, lim_wide));
            end else if (cmd[CMD_RIGHT]) begin
                center_r_next = DATAW'(sat_add(cr_wide, step_wide, lim_wide));
            end else if (cmd[CMD_UP]) begin
                center_i_next = DATAW'(sat_add(ci_wide, -step_wide, lim_wide));
            end else if (cmd[CMD_DOWN]) begin
                center_i_next = DATAW'(sat_add(ci_wide, step_wide, lim_wide));
            end
        end
    end

    // View registers; next values already hold their old value when nothing is applied
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            center_r <= DATAW'(INIT_CENTER_R);
            center_i <= DATAW'(INIT_CENTER_I);
            delta    <= DATAW'(INIT_DELTA);
        end else begin
            center_r <= center_r_next;
            center_i <= center_i_next;
            delta    <= delta_next;
        end
    end

`ifdef MANDEL_AUTO_ITER_EN
    localparam logic [ITERW-1:0] ITER_TOP  = {ITERW{1'b1}};
    localparam logic [ITERW-1:0] ITER_BASE = ITERW'(MAX_ITER);
    localparam logic [ITERW-1:0] ITER_STEP = ITERW'(32);

    logic [ITERW-1:0] max_iter_reg;
    logic [ITERW-1:0] max_iter_next;

    // Deeper zoom gets more iterations, bounded above by the counter width and below by the base limit
    always_comb begin
        max_iter_next = max_iter_reg;
        if (apply) begin
            if (cmd[CMD_HOME])
                max_iter_next = ITER_BASE;
            else if (cmd[CMD_ZOOM_IN])
                max_iter_next = (max_iter_reg > ITER_TOP - ITER_STEP) ? ITER_TOP : max_iter_reg + ITER_STEP;
            else if (cmd[CMD_ZOOM_OUT])
                max_iter_next = (max_iter_reg < ITER_BASE + ITER_STEP) ? ITER_BASE : max_iter_reg - ITER_STEP;
        end
    end

    // Iteration limit register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            max_iter_reg <= ITER_BASE;
        else
            max_iter_reg <= max_iter_next;
    end

    assign max_iter = max_iter_reg;
`else
    assign max_iter = ITERW'(MAX_ITER);
`endif

endmodule

// File: rtl/mandelbrot_frame_ctrl.sv
// Frame sequencer: queues pan/zoom commands, programs the engine per frame and
// streams engine pixels into the framebuffer with back-pressure.
// Optional feature macro: MANDEL_AUTO_ITER_EN (iteration limit follows zoom level).
module mandelbrot_frame_ctrl
    import mandelbrot_pkg::*;
#(
    parameter int HSIZE = 640,
    parameter int VSIZE = 480,
    parameter int DATAW = 32,
    parameter int IMAGW = 28,
    parameter int ITERW = 16,
    parameter int RCNTW = 10,
    parameter int ICNTW = 10,
    parameter int FBAW  = 19
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cmd_zoom_in,
    input  logic                   cmd_zoom_out,
    input  logic                   cmd_left,
    input  logic                   cmd_right,
    input  logic                   cmd_up,
    input  logic                   cmd_down,
    input  logic                   cmd_home,
    output logic                   eng_start,
    output logic                   eng_stall,
    output logic [DATAW-1:0]       eng_start_real,
    output logic [DATAW-1:0]       eng_start_imag,
    output logic [DATAW-1:0]       eng_delta_real,
    output logic [DATAW-1:0]       eng_delta_imag,
    output logic [RCNTW-1:0]       eng_real_size,
    output logic [ICNTW-1:0]       eng_imag_size,
    output logic [ITERW-1:0]       eng_max_iteration,
    input  logic                   eng_valid,
    input  logic [RCNTW-1:0]       eng_real_cnt,
    input  logic [ICNTW-1:0]       eng_imag_cnt,
    input  logic [`RGB_SIZE-1:0]   eng_color,
    output logic                   fb_we,
    output logic [FBAW-1:0]        fb_addr,
    output logic [`RGB_SIZE-1:0]   fb_wdata,
    input  logic                   fb_ready,
    output logic                   busy,
    output logic                   frame_done
);

    localparam logic [FBAW-1:0]  LAST_PIX    = FBAW'(HSIZE * VSIZE - 1);
    localparam logic [DATAW-1:0] HALF_H      = DATAW'(HSIZE / 2);
    localparam logic [DATAW-1:0] HALF_V      = DATAW'(VSIZE / 2);
    localparam logic [DATAW-1:0] RST_START_R = DATAW'(INIT_CENTER_R) - DATAW'(INIT_DELTA) * HALF_H;
    localparam logic [DATAW-1:0] RST_START_I = DATAW'(INIT_CENTER_I) - DATAW'(INIT_DELTA) * HALF_V;

    state_t                state;
    logic [NUM_CMDS-1:0]   cmd_vec;
    logic [NUM_CMDS-1:0]   pend;
    logic [NUM_CMDS-1:0]   cmd_sel;
    logic [NUM_CMDS-1:0]   clear_mask;
    logic [FBAW-1:0]       pixel_cnt;
    logic [DATAW-1:0]      start_real;
    logic [DATAW-1:0]      start_imag;
    logic [DATAW-1:0]      delta;
    logic [DATAW-1:0]      center_r_next;
    logic [DATAW-1:0]      center_i_next;
    logic [DATAW-1:0]      delta_next;
    logic                  in_setup;
    logic                  in_run;
    logic                  accept;
    logic                  any_cmd;

    assign cmd_vec    = {cmd_down, cmd_up, cmd_right, cmd_left, cmd_zoom_out, cmd_zoom_in, cmd_home};
    assign cmd_sel    = pick_cmd(pend);
    assign in_setup   = (state == ST_SETUP);
    assign in_run     = (state == ST_RUN);
    assign clear_mask = in_setup ? cmd_sel : '0;
    assign any_cmd    = (|pend) | (|cmd_vec);

    mandelbrot_view_reg #(
        .DATAW (DATAW),
        .IMAGW (IMAGW),
        .ITERW (ITERW)
    ) u_view (
        .clk           (clk),
        .rst_n         (rst_n),
        .apply         (in_setup),
        .cmd           (cmd_sel),
        .delta         (delta),
        .center_r_next (center_r_next),
        .center_i_next (center_i_next),
        .delta_next    (delta_next),
        .max_iter      (eng_max_iteration)
    );

    // Pixel handshake is live only while a frame is running
    assign accept    = in_run & eng_valid & fb_ready;
    assign fb_we     = in_run & eng_valid;
    assign eng_stall = in_run & ~fb_ready;
    assign fb_addr   = FBAW'(eng_imag_cnt) * FBAW'(HSIZE) + FBAW'(eng_real_cnt);
    assign fb_wdata  = eng_color;

    assign eng_start_real = start_real;
    assign eng_start_imag = start_imag;
    assign eng_delta_real = delta;
    assign eng_delta_imag = delta;
    assign eng_real_size  = RCNTW'(HSIZE);
    assign eng_imag_size  = ICNTW'(VSIZE);
    assign busy           = (state != ST_IDLE);

    // Sticky command flags; a new pulse wins over the clear of the command being applied
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pend <= '0;
        else
            pend <= (pend & ~clear_mask) | cmd_vec;
    end

    // Frame FSM with registered start/done pulses and the accepted-pixel counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_SETUP;
            eng_start  <= 1'b0;
            frame_done <= 1'b0;
            pixel_cnt  <= '0;
            start_real <= RST_START_R;
            start_imag <= RST_START_I;
        end else begin
            eng_start  <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (any_cmd)
                        state <= ST_SETUP;
                end
                ST_SETUP: begin
                    // Corner is derived from the view as it will be after this command
                    start_real <= center_r_next - delta_next * HALF_H;
                    start_imag <= center_i_next - delta_next * HALF_V;
                    eng_start  <= 1'b1;
                    state      <= ST_START;
                end
                ST_START: begin
                    pixel_cnt <= '0;
                    state     <= ST_RUN;
                end
                ST_RUN: begin
                    if (accept) begin
                        if (pixel_cnt == LAST_PIX) begin
                            frame_done <= 1'b1;
                            state      <= ST_DONE;
                        end else begin
                            pixel_cnt <= pixel_cnt + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state <= any_cmd ? ST_SETUP : ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mandelbrot_frame_ctrl.sv
// Self-checking bench for mandelbrot_frame_ctrl on a reduced 8x4 frame.
// Optional feature macro: MANDEL_AUTO_ITER_EN (the iteration model follows it).
`timescale 1ns/1ps
`ifndef RGB_SIZE
`define RGB_SIZE 24
`endif

module tb_mandelbrot_frame_ctrl;

    localparam int HSIZE = 8;
    localparam int VSIZE = 4;
    localparam int DATAW = 32;
    localparam int ITERW = 16;
    localparam int RCNTW = 10;
    localparam int ICNTW = 10;
    localparam int FBAW  = 19;
    localparam int TOTAL = HSIZE * VSIZE;
    localparam int RGBW  = `RGB_SIZE;

    localparam longint INIT_CR = -134217728;   // 0xF8000000 = -0.5
    localparam longint INIT_D  = 1258291;
    localparam longint DMAX    = 16777216;
    localparam longint LIM     = 536870912;    // 2.0

    localparam logic [6:0] C_HOME  = 7'h01;
    localparam logic [6:0] C_ZIN   = 7'h02;
    localparam logic [6:0] C_ZOUT  = 7'h04;
    localparam logic [6:0] C_LEFT  = 7'h08;
    localparam logic [6:0] C_RIGHT = 7'h10;
    localparam logic [6:0] C_UP    = 7'h20;
    localparam logic [6:0] C_DOWN  = 7'h40;

    logic clk;
    logic rst_n;
    logic cmd_zoom_in, cmd_zoom_out, cmd_left, cmd_right, cmd_up, cmd_down, cmd_home;
    logic eng_start, eng_stall;
    logic [DATAW-1:0] eng_start_real, eng_start_imag, eng_delta_real, eng_delta_imag;
    logic [RCNTW-1:0] eng_real_size;
    logic [ICNTW-1:0] eng_imag_size;
    logic [ITERW-1:0] eng_max_iteration;
    logic eng_valid;
    logic [RCNTW-1:0] eng_real_cnt;
    logic [ICNTW-1:0] eng_imag_cnt;
    logic [RGBW-1:0]  eng_color;
    logic fb_we;
    logic [FBAW-1:0]  fb_addr;
    logic [RGBW-1:0]  fb_wdata;
    logic fb_ready;
    logic busy;
    logic frame_done;

    mandelbrot_frame_ctrl #(
        .HSIZE (HSIZE), .VSIZE (VSIZE), .DATAW (DATAW), .IMAGW (28), .ITERW (ITERW),
        .RCNTW (RCNTW), .ICNTW (ICNTW), .FBAW (FBAW)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .cmd_zoom_in       (cmd_zoom_in),
        .cmd_zoom_out      (cmd_zoom_out),
        .cmd_left          (cmd_left),
        .cmd_right         (cmd_right),
        .cmd_up            (cmd_up),
        .cmd_down          (cmd_down),
        .cmd_home          (cmd_home),
        .eng_start         (eng_start),
        .eng_stall         (eng_stall),
        .eng_start_real    (eng_start_real),
        .eng_start_imag    (eng_start_imag),
        .eng_delta_real    (eng_delta_real),
        .eng_delta_imag    (eng_delta_imag),
        .eng_real_size     (eng_real_size),
        .eng_imag_size     (eng_imag_size),
        .eng_max_iteration (eng_max_iteration),
        .eng_valid         (eng_valid),
        .eng_real_cnt      (eng_real_cnt),
        .eng_imag_cnt      (eng_imag_cnt),
        .eng_color         (eng_color),
        .fb_we             (fb_we),
        .fb_addr           (fb_addr),
        .fb_wdata          (fb_wdata),
        .fb_ready          (fb_ready),
        .busy              (busy),
        .frame_done        (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total_cnt = 0;
    int pass_cnt  = 0;

    typedef struct {
        logic [FBAW-1:0] addr;
        logic [RGBW-1:0] color;
    } exp_t;
    exp_t sb[$];

    // Reference view model
    longint     m_cr, m_ci, m_d;
    int         m_it;
    logic [6:0] m_pend;

    function automatic longint clampv(input longint v);
        if (v > LIM) return LIM;
        if (v < -LIM) return -LIM;
        return v;
    endfunction

    task automatic model_reset();
        m_cr = INIT_CR; m_ci = 0; m_d = INIT_D; m_it = 256; m_pend = 7'h0;
    endtask

    task automatic model_apply();
        bit found;
        found = 0;
        for (int k = 0; k < 7; k++) begin
            if (!found && m_pend[k]) begin
                found = 1;
                m_pend[k] = 1'b0;
                case (k)
                    0: begin m_cr = INIT_CR; m_ci = 0; m_d = INIT_D; m_it = 256; end
                    1: begin
                        m_d = m_d / 2;
                        if (m_d < 1) m_d = 1;
`ifdef MANDEL_AUTO_ITER_EN
                        m_it = (m_it + 32 > 65535) ? 65535 : m_it + 32;
`endif
                    end
                    2: begin
                        m_d = m_d * 2;
                        if (m_d > DMAX) m_d = DMAX;
`ifdef MANDEL_AUTO_ITER_EN
                        m_it = (m_it - 32 < 256) ? 256 : m_it - 32;
`endif
                    end
                    3: m_cr = clampv(m_cr - m_d * 32);
                    4: m_cr = clampv(m_cr + m_d * 32);
                    5: m_ci = clampv(m_ci - m_d * 32);
                    default: m_ci = clampv(m_ci + m_d * 32);
                endcase
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmds(input logic [6:0] mask);
        cmd_home     = mask[0];
        cmd_zoom_in  = mask[1];
        cmd_zoom_out = mask[2];
        cmd_left     = mask[3];
        cmd_right    = mask[4];
        cmd_up       = mask[5];
        cmd_down     = mask[6];
        m_pend = m_pend | mask;
    endtask

    // Compare the engine programming against the model while eng_start is high
    task automatic check_settings();
        logic [31:0] e_sr, e_si, e_d;
        logic [15:0] e_it;
        e_sr = 32'(m_cr - m_d * (HSIZE / 2));
        e_si = 32'(m_ci - m_d * (VSIZE / 2));
        e_d  = 32'(m_d);
        e_it = 16'(m_it);
        total_cnt++;
        if (eng_start_real !== e_sr) $display("FAIL start_real got %h want %h", eng_start_real, e_sr);
        else pass_cnt++;
        total_cnt++;
        if (eng_start_imag !== e_si) $display("FAIL start_imag got %h want %h", eng_start_imag, e_si);
        else pass_cnt++;
        total_cnt++;
        if (eng_delta_real !== e_d || eng_delta_imag !== e_d)
            $display("FAIL delta got %0d/%0d want %0d", eng_delta_real, eng_delta_imag, e_d);
        else pass_cnt++;
        total_cnt++;
        if (eng_max_iteration !== e_it) $display("FAIL max_iter got %0d want %0d", eng_max_iteration, e_it);
        else pass_cnt++;
    endtask

    task automatic wait_start(input int budget);
        int n;
        n = 0;
        while (eng_start !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        total_cnt++;
        if (eng_start !== 1'b1) $display("FAIL start_timeout got %b want 1 within %0d cycles", eng_start, budget);
        else pass_cnt++;
        model_apply();
        check_settings();
        $display("frame start: start_real=%h start_imag=%h delta=%0d", eng_start_real, eng_start_imag, eng_delta_real);
    endtask

    // Behavioural engine: raster pixels, optional random gaps and framebuffer stalls
    task automatic run_frame(input bit rnd, input logic [6:0] mid_a, input logic [6:0] mid_b);
        int r, i, acc, cyc, last_addr;
        bit hold;
        logic [TOTAL-1:0] seen_vec;
        exp_t e;
        r = 0; i = 0; acc = 0; hold = 0; last_addr = -1; seen_vec = '0;
        for (cyc = 0; acc < TOTAL && cyc < 40 * TOTAL; cyc++) begin
            step();
            set_cmds(cyc == 3 ? mid_a : (cyc == 5 ? mid_b : 7'h0));
            fb_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (!hold) begin
                if (rnd && $urandom_range(0, 3) == 0) begin
                    eng_valid = 1'b0;
                end else begin
                    eng_valid    = 1'b1;
                    eng_real_cnt = RCNTW'(r);
                    eng_imag_cnt = ICNTW'(i);
                    eng_color    = RGBW'($urandom);
                    e.addr  = FBAW'(i * HSIZE + r);
                    e.color = eng_color;
                    sb.push_back(e);
                    hold = 1;
                end
            end
            #1;
            total_cnt++;
            if (eng_stall !== ~fb_ready || fb_we !== eng_valid)
                $display("FAIL handshake stall=%b we=%b want stall=%b we=%b", eng_stall, fb_we, ~fb_ready, eng_valid);
            else pass_cnt++;
            if (eng_valid && fb_ready) begin
                e = sb.pop_front();
                total_cnt++;
                if (fb_addr !== e.addr || fb_wdata !== e.color)
                    $display("FAIL fb_write got addr=%0d data=%h want addr=%0d data=%h", fb_addr, fb_wdata, e.addr, e.color);
                else pass_cnt++;
                if (fb_addr < FBAW'(TOTAL)) begin
                    total_cnt++;
                    if (seen_vec[int'(fb_addr)] !== 1'b0) $display("FAIL dup_addr got addr=%0d written twice want once", fb_addr);
                    else pass_cnt++;
                    seen_vec[int'(fb_addr)] = 1'b1;
                end
                last_addr = int'(fb_addr);
                hold = 0;
                acc++;
                r++;
                if (r == HSIZE) begin r = 0; i++; end
            end
        end
        step();
        eng_valid = 1'b0;
        set_cmds(7'h0);
        fb_ready = 1'b1;
        #1;
        total_cnt++;
        if (seen_vec !== {TOTAL{1'b1}} || last_addr != TOTAL - 1)
            $display("FAIL frame_writes got mask=%h last=%0d want all, last=%0d", seen_vec, last_addr, TOTAL - 1);
        else pass_cnt++;
        total_cnt++;
        if (frame_done !== 1'b1 || busy !== 1'b1) $display("FAIL frame_done_pulse got %b busy=%b want 1 busy=1", frame_done, busy);
        else pass_cnt++;
        step();
        total_cnt++;
        if (frame_done !== 1'b0 || busy !== (m_pend != 7'h0))
            $display("FAIL after_done got done=%b busy=%b want done=0 busy=%b", frame_done, busy, m_pend != 7'h0);
        else pass_cnt++;
        $display("frame end: writes=%0d last_addr=%0d pending=%b", acc, last_addr, m_pend);
        sb.delete();
    endtask

    task automatic do_cmd_frame(input logic [6:0] mask);
        set_cmds(mask);
        step();
        set_cmds(7'h0);
        wait_start(4);
        run_frame(0, 7'h0, 7'h0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        eng_valid = 1'b1;
        fb_ready = 1'b0;
        repeat (3) step();
        total_cnt++;
        if (eng_start !== 1'b0 || frame_done !== 1'b0 || busy !== 1'b1)
            $display("FAIL reset_ctrl got start=%b done=%b busy=%b want 0 0 1", eng_start, frame_done, busy);
        else pass_cnt++;
        total_cnt++;
        if (fb_we !== 1'b0 || eng_stall !== 1'b0)
            $display("FAIL reset_handshake got we=%b stall=%b want 0 0", fb_we, eng_stall);
        else pass_cnt++;
        total_cnt++;
        if (eng_real_size !== RCNTW'(HSIZE) || eng_imag_size !== ICNTW'(VSIZE))
            $display("FAIL sizes got %0d x %0d want %0d x %0d", eng_real_size, eng_imag_size, HSIZE, VSIZE);
        else pass_cnt++;
        rst_n = 1'b1;
        eng_valid = 1'b0;
        fb_ready = 1'b1;
        model_reset();
        wait_start(3);
        total_cnt++;
        if (eng_start_real !== 32'(INIT_CR - INIT_D * 4))
            $display("FAIL reset_start_real got %h want %h", eng_start_real, 32'(INIT_CR - INIT_D * 4));
        else pass_cnt++;
        run_frame(0, 7'h0, 7'h0);
    endtask

    task automatic test_backpressure();
        set_cmds(C_RIGHT);
        step();
        set_cmds(7'h0);
        total_cnt++;
        if (eng_start !== 1'b0 || busy !== 1'b1) $display("FAIL latency_1 got start=%b busy=%b want 0 1", eng_start, busy);
        else pass_cnt++;
        step();
        total_cnt++;
        if (eng_start !== 1'b1) $display("FAIL latency_2 got start=%b want 1", eng_start);
        else pass_cnt++;
        model_apply();
        check_settings();
        run_frame(1, 7'h0, 7'h0);
    endtask

    task automatic test_queued();
        do_cmd_frame(C_HOME);
        set_cmds(C_DOWN);
        step();
        set_cmds(7'h0);
        wait_start(4);
        run_frame(1, C_ZIN | C_LEFT, C_ZIN);
        wait_start(4);
        total_cnt++;
        if (eng_delta_real !== 32'd629145) $display("FAIL queued_zoom got %0d want 629145", eng_delta_real);
        else pass_cnt++;
        run_frame(0, 7'h0, 7'h0);
        wait_start(4);
        total_cnt++;
        if (eng_start_real !== 32'(INIT_CR - 629145 * 36))
            $display("FAIL queued_left got %h want %h", eng_start_real, 32'(INIT_CR - 629145 * 36));
        else pass_cnt++;
        run_frame(0, 7'h0, 7'h0);
    endtask

    task automatic test_zoom_limits();
        do_cmd_frame(C_HOME);
        repeat (6) do_cmd_frame(C_ZOUT);
        total_cnt++;
        if (eng_delta_real !== 32'd16777216) $display("FAIL zoom_out_cap got %0d want 16777216", eng_delta_real);
        else pass_cnt++;
        repeat (30) do_cmd_frame(C_ZIN);
        total_cnt++;
        if (eng_delta_real !== 32'd1) $display("FAIL zoom_in_floor got %0d want 1", eng_delta_real);
        else pass_cnt++;
    endtask

    task automatic test_pan_saturate();
        do_cmd_frame(C_HOME);
        repeat (200) do_cmd_frame(C_RIGHT);
        total_cnt++;
        if (eng_start_real !== 32'(LIM - INIT_D * 4))
            $display("FAIL pan_sat got %h want %h", eng_start_real, 32'(LIM - INIT_D * 4));
        else pass_cnt++;
    endtask

    task automatic test_async_reset();
        set_cmds(C_ZIN);
        step();
        set_cmds(7'h0);
        wait_start(4);
        step();
        eng_valid = 1'b1;
        eng_real_cnt = '0;
        eng_imag_cnt = '0;
        fb_ready = 1'b1;
        step();
        set_cmds(C_UP);
        step();
        set_cmds(7'h0);
        fb_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if (eng_start !== 1'b0 || frame_done !== 1'b0 || fb_we !== 1'b0 || eng_stall !== 1'b0 || busy !== 1'b1)
            $display("FAIL async_reset got start=%b done=%b we=%b stall=%b busy=%b want 0 0 0 0 1",
                     eng_start, frame_done, fb_we, eng_stall, busy);
        else pass_cnt++;
        total_cnt++;
        if (eng_delta_real !== 32'(INIT_D)) $display("FAIL async_reset_delta got %0d want %0d", eng_delta_real, INIT_D);
        else pass_cnt++;
        step();
        step();
        rst_n = 1'b1;
        eng_valid = 1'b0;
        fb_ready = 1'b1;
        model_reset();
        wait_start(3);
        run_frame(0, 7'h0, 7'h0);
    endtask

    initial begin
        rst_n = 1'b0;
        eng_valid = 1'b0;
        eng_real_cnt = '0;
        eng_imag_cnt = '0;
        eng_color = '0;
        fb_ready = 1'b1;
        model_reset();
        set_cmds(7'h0);
        test_reset();
        test_backpressure();
        test_queued();
        test_zoom_limits();
        test_pan_saturate();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/mandelbrot_frame_ctrl.md
Name: mandelbrot_frame_ctrl

Overview:
Frame-level sequencer for the colored Mandelbrot engine. It holds the view state (center, pixel delta, max iteration), converts it to engine start/delta/size settings, and pulses start. It then streams each valid pixel into the framebuffer write port, back-pressuring the engine via stall. User pan/zoom commands are queued while a frame renders and applied at frame end.

Parameters:
HSIZE, 640, pixels per line (engine real_size)
VSIZE, 480, lines per frame (engine imag_size)
DATAW, 32, signed fixed-point width
IMAGW, 28, fraction bits (Q4.28)
ITERW, 16, iteration width
RCNTW/ICNTW, 10/10, engine counter widths
FBAW, 19, framebuffer address width (>= clog2(HSIZE*VSIZE))
INIT_CENTER_R / INIT_CENTER_I / INIT_DELTA, 32'hF8000000 / 0 / 32'd1258291, reset view (-0.5, 0, 3/640)
DELTA_MAX, 32'd16777216, zoom-out clamp (1/16)
PAN_SHIFT, 5, pan step = delta<<PAN_SHIFT (32 pixels)
MAX_ITER, 256, fixed iteration limit

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
cmd_zoom_in, cmd_zoom_out, cmd_left, cmd_right, cmd_up, cmd_down, cmd_home  in  1 each  single-cycle command pulses
eng_start  out  1  one-cycle engine start
eng_stall  out  1  engine stall
eng_start_real, eng_start_imag, eng_delta_real, eng_delta_imag  out  DATAW  engine view settings
eng_real_size / eng_imag_size  out  RCNTW / ICNTW  HSIZE / VSIZE constants
eng_max_iteration  out  ITERW  iteration limit
eng_valid  in  1  engine pixel valid
eng_real_cnt / eng_imag_cnt  in  RCNTW / ICNTW  pixel coordinate
eng_color  in  `RGB_SIZE  pixel color
fb_we  out  1  framebuffer write
fb_addr  out  FBAW  eng_imag_cnt*HSIZE + eng_real_cnt
fb_wdata  out  `RGB_SIZE  = eng_color
fb_ready  in  1  framebuffer can accept write
busy  out  1  state != IDLE
frame_done  out  1  one-cycle pulse at frame end

Behaviour:
- Clock clk; reset rst_n asynchronous active-low. On reset: state=SETUP (auto first frame), center/delta=INIT_*, max_iter=MAX_ITER, pending=0, eng_start=0, frame_done=0, pixel_cnt=0. Combinational outputs follow.
- FSM: IDLE -> SETUP when a command is pending or arrives. SETUP (1 cycle): apply one pending command, register start_real=center_r-delta*(HSIZE/2), start_imag=center_i-delta*(VSIZE/2), both wrapping at DATAW. START (1 cycle): eng_start=1, pixel_cnt=0. RUN until pixel_cnt==HSIZE*VSIZE-1 is accepted. DONE (1 cycle): frame_done=1, then SETUP if pending else IDLE.
- Latency: command in IDLE -> eng_start asserted 2 cycles later.
- Settings registers change only in SETUP; stable through RUN.
- Pixel handshake (RUN only): fb_we = eng_valid; eng_stall = ~fb_ready; accept = eng_valid & fb_ready; pixel_cnt++ per accept. Engine holds valid/data while stalled. Outside RUN fb_we=0, eng_stall=0.
- Commands: each pulse sets a sticky pending bit, any state, including same cycle as DONE. SETUP applies the single highest priority and clears only it: home > zoom_in > zoom_out > left > right > up > down. Multiple same-type pulses during one frame collapse to one.
- Zoom in: delta>>>1, floor 1. Zoom out: delta<<1, clamp DELTA_MAX. home: restore INIT_* (and MAX_ITER).
- Pan: center ∓/± (delta<<PAN_SHIFT), saturated to [-2^29, 2^29] (±2.0). Left/up subtract, right/down add.
- eng_valid outside RUN: ignored, not counted.

Optional Feature:
MANDEL_AUTO_ITER_EN: defined -> zoom_in adds 32 to max_iter (saturate 2^ITERW-1), zoom_out subtracts 32 (floor MAX_ITER), home restores MAX_ITER. Undefined -> eng_max_iteration tied to MAX_ITER, no register.

Decomposition:
- Package mandelbrot_pkg: state enum, command-index enum/priority encoding, Q4.28 constants (ONE, TWO, INIT_*), saturating-add function.
- One sub-module, mandelbrot_view_reg: center/delta/max_iter update logic for a decoded command; the FSM stays in mandelbrot_frame_ctrl.

Test Plan:
- Reset release -> eng_start within 3 cycles; eng_start_real=32'hF8000000-1258291*320, eng_delta=1258291; after 307200 accepts, frame_done pulses once; busy=0.
- fb_ready toggled randomly 50% during RUN -> eng_stall=~fb_ready; 307200 fb_we&fb_ready writes, last fb_addr=307199, no duplicate addresses.
- cmd_zoom_in twice plus cmd_left mid-frame -> one frame with delta=629145 (left pending), then frame with center_r shifted by -629145<<5.
- Repeated zoom_out from INIT -> delta caps at 16777216; 30 zoom_in -> delta floors at 1.
- 200 cmd_right pulses (each after frame_done) -> center_r saturates at 32'h20000000.
- rst_n asserted mid-RUN -> outputs reset asynchronously; on release new frame starts from INIT_* with pending cleared.
